// File: rtl/ls_err_mon.sv
// ls_err_mon: multi-channel latch/shift-register error monitor.
// Compares test-chip outputs Q against a latency-aligned copy of the
// generator reference DATA. Errors are counted per channel, with saturation,
// only after an explicit arm and an in-sync qualification window.
// Optional first-error timestamps are enabled with LS_ERR_MON_FIRST_TS_EN.
module ls_err_mon #(
   parameter int unsigned CH       = 4,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned DLY_W    = 4,
   parameter int unsigned SYNC_LEN = 8,
   parameter int unsigned TS_W     = 32,
   localparam int unsigned SEL_W   = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CLR,
   input  logic             ARM,
   input  logic             STOP,
   input  logic [DLY_W-1:0] LAT,
   input  logic [CH-1:0]    Q,
   input  logic [CH-1:0]    DATA,
   input  logic [SEL_W-1:0] SEL,
   output logic [CNT_W-1:0] ERR_CNT,
   output logic [CH-1:0]    ERR_SAT,
   output logic             ERR_ANY,
   output logic [1:0]       STATE,
   output logic [TS_W-1:0]  FIRST_TS
);

   localparam int unsigned DEPTH = 2 ** DLY_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      RUN  = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t           state;
   logic [7:0]       match_cnt;
   logic [DLY_W-1:0] lat_q;

   logic [CH-1:0]    q_r;
   logic [CH-1:0]    dline [DEPTH];
   logic [CH-1:0]    mis;

   logic [CNT_W-1:0] cnt     [CH];
   logic [CNT_W-1:0] cnt_nxt [CH];
   logic [CH-1:0]    sat;
   logic [CH-1:0]    sat_nxt;
   logic [CH-1:0]    inc;
   logic [CNT_W-1:0] sel_cnt;
   logic             any_nxt;

   // Input registers, DATA alignment delay line and registered mismatch vector
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         q_r <= '0;
         mis <= '0;
         for (int unsigned k = 0; k < DEPTH; k++) dline[k] <= '0;
      end else begin
         q_r      <= Q;
         dline[0] <= DATA;
         for (int unsigned k = 1; k < DEPTH; k++) dline[k] <= dline[k-1];
         mis      <= q_r ^ dline[lat_q];
      end
   end

   // Control FSM: arm, in-sync qualification, counting, hold
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         match_cnt <= '0;
         lat_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               lat_q <= LAT;
               if (STOP) begin
                  state <= HOLD;
               end else if (ARM) begin
                  state     <= SYNC;
                  match_cnt <= '0;
               end
            end
            SYNC: begin
               if (STOP) begin
                  state <= HOLD;
               end else if (mis == '0) begin
                  if (match_cnt == 8'(SYNC_LEN - 1)) begin
                     state     <= RUN;
                     match_cnt <= '0;
                  end else begin
                     match_cnt <= match_cnt + 8'd1;
                  end
               end else begin
                  match_cnt <= '0;
               end
            end
            RUN: begin
               if (STOP) state <= HOLD;
            end
            HOLD: begin
               lat_q <= LAT;
               if (ARM && !STOP) begin
                  state     <= SYNC;
                  match_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign STATE   = state;
   assign ERR_SAT = sat;

   // Next-state of the per-channel saturating counters and sticky flags;
   // readout registers take next-state values so a pin error shows at n+3+LAT
   always_comb begin
      sel_cnt = '0;
      any_nxt = 1'b0;
      inc     = '0;
      sat_nxt = sat;
      for (int unsigned i = 0; i < CH; i++) begin
         cnt_nxt[i] = cnt[i];
         inc[i]     = (state == RUN) && mis[i] && (cnt[i] != '1);
         if (CLR) begin
            cnt_nxt[i] = '0;
            sat_nxt[i] = 1'b0;
         end else if (inc[i]) begin
            cnt_nxt[i] = cnt[i] + 1'b1;
            if (cnt_nxt[i] == '1) sat_nxt[i] = 1'b1;
         end
         if (SEL == SEL_W'(i)) sel_cnt = cnt_nxt[i];
         if (cnt_nxt[i] != '0) any_nxt = 1'b1;
      end
   end

   // Counter state and registered readout
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int unsigned i = 0; i < CH; i++) cnt[i] <= '0;
         sat     <= '0;
         ERR_CNT <= '0;
         ERR_ANY <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < CH; i++) cnt[i] <= cnt_nxt[i];
         sat     <= sat_nxt;
         ERR_CNT <= sel_cnt;
         ERR_ANY <= any_nxt;
      end
   end

`ifdef LS_ERR_MON_FIRST_TS_EN
   logic [TS_W-1:0] ts;
   logic [TS_W-1:0] ts_lat     [CH];
   logic [TS_W-1:0] ts_lat_nxt [CH];
   logic [CH-1:0]   ts_vld;
   logic [CH-1:0]   ts_vld_nxt;
   logic [TS_W-1:0] sel_ts;

   // First-error capture per channel and selected timestamp for readout
   always_comb begin
      sel_ts     = '0;
      ts_vld_nxt = ts_vld;
      for (int unsigned i = 0; i < CH; i++) begin
         ts_lat_nxt[i] = ts_lat[i];
         if (CLR) begin
            ts_lat_nxt[i] = '0;
            ts_vld_nxt[i] = 1'b0;
         end else if (inc[i] && !ts_vld[i]) begin
            ts_lat_nxt[i] = ts;
            ts_vld_nxt[i] = 1'b1;
         end
         if ((SEL == SEL_W'(i)) && ts_vld_nxt[i]) sel_ts = ts_lat_nxt[i];
      end
   end

   // RUN cycle counter (held at 0 outside RUN, so it restarts on every entry)
   // and timestamp storage
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ts       <= '0;
         ts_vld   <= '0;
         FIRST_TS <= '0;
         for (int unsigned i = 0; i < CH; i++) ts_lat[i] <= '0;
      end else begin
         if (CLR || (state != RUN)) ts <= '0;
         else if (ts != '1)         ts <= ts + 1'b1;
         ts_vld   <= ts_vld_nxt;
         FIRST_TS <= sel_ts;
         for (int unsigned i = 0; i < CH; i++) ts_lat[i] <= ts_lat_nxt[i];
      end
   end
`else
   assign FIRST_TS = '0;
`endif

endmodule

// File: tb/tb_ls_err_mon.sv
// Directed self-checking bench for ls_err_mon (CH=4, CNT_W=4, DLY_W=4).
// Timestamp expectations follow LS_ERR_MON_FIRST_TS_EN when it is defined.
module tb_ls_err_mon;

   logic        CLK = 1'b0;
   logic        RST;
   logic        CLR;
   logic        ARM;
   logic        STOP;
   logic [3:0]  LAT;
   logic [3:0]  Q;
   logic [3:0]  DATA;
   logic [1:0]  SEL;
   logic [3:0]  ERR_CNT;
   logic [3:0]  ERR_SAT;
   logic        ERR_ANY;
   logic [1:0]  STATE;
   logic [31:0] FIRST_TS;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [3:0]  pat  = 4'd0;
   logic [3:0]  flip = 4'd0;
   int unsigned qdly = 0;
   logic [3:0]  hist [16];

   ls_err_mon #(
      .CH      (4),
      .CNT_W   (4),
      .DLY_W   (4),
      .SYNC_LEN(8),
      .TS_W    (32)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .CLR     (CLR),
      .ARM     (ARM),
      .STOP    (STOP),
      .LAT     (LAT),
      .Q       (Q),
      .DATA    (DATA),
      .SEL     (SEL),
      .ERR_CNT (ERR_CNT),
      .ERR_SAT (ERR_SAT),
      .ERR_ANY (ERR_ANY),
      .STATE   (STATE),
      .FIRST_TS(FIRST_TS)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Q is DATA delayed by qdly cycles, with the channels in flip inverted
   task automatic drive_q();
      logic [3:0] src;
      src = (qdly == 0) ? DATA : hist[qdly-1];
      Q   = src ^ flip;
   endtask

   task automatic set_flip(input logic [3:0] m);
      flip = m;
      drive_q();
   endtask

   task automatic cyc(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) begin
         @(posedge CLK);
         #1;
         for (int j = 15; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = DATA;
         pat     = 4'(pat * 4'd5 + 4'd3);
         DATA    = pat;
         drive_q();
      end
   endtask

   task automatic rd(input logic [1:0] s);
      SEL = s;
      cyc(1);
   endtask

   task automatic pulse_arm();
      ARM = 1'b1; cyc(1); ARM = 1'b0;
   endtask

   task automatic pulse_stop();
      STOP = 1'b1; cyc(1); STOP = 1'b0;
   endtask

   task automatic pulse_clr();
      CLR = 1'b1; cyc(1); CLR = 1'b0;
   endtask

   task automatic wait_state(input string tag, input logic [1:0] s, input int unsigned budget);
      int unsigned k = 0;
      while ((STATE !== s) && (k < budget)) begin
         cyc(1);
         k++;
      end
      chk(tag, {30'd0, STATE}, {30'd0, s});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) hist[i] = 4'd0;
      RST = 1'b1; CLR = 1'b0; ARM = 1'b0; STOP = 1'b0;
      LAT = 4'd0; SEL = 2'd2; DATA = 4'd0; Q = 4'd0;
      cyc(3);
      chk("rst_cnt",   {28'd0, ERR_CNT}, 32'd0);
      chk("rst_sat",   {28'd0, ERR_SAT}, 32'd0);
      chk("rst_any",   {31'd0, ERR_ANY}, 32'd0);
      chk("rst_state", {30'd0, STATE},   32'd0);
      chk("rst_ts",    FIRST_TS,         32'd0);
      RST = 1'b0;
      cyc(2);

      // basic qualification and counting on ch2
      pulse_arm();
      wait_state("sync_to_run", 2'd2, 30);
      set_flip(4'b0100); cyc(5); set_flip(4'b0000); cyc(4);
      chk("ch2_cnt5", {28'd0, ERR_CNT}, 32'd5);
      rd(2'd0);
      chk("ch0_cnt0", {28'd0, ERR_CNT}, 32'd0);
      chk("any_set",  {31'd0, ERR_ANY}, 32'd1);
      chk("sat_none", {28'd0, ERR_SAT}, 32'd0);

      // stop, frozen readout, clear
      pulse_stop();
      chk("stop_hold", {30'd0, STATE}, 32'd3);
      rd(2'd2);
      chk("hold_cnt5", {28'd0, ERR_CNT}, 32'd5);
      pulse_clr(); cyc(1);
      chk("clr_cnt", {28'd0, ERR_CNT}, 32'd0);
      chk("clr_any", {31'd0, ERR_ANY}, 32'd0);

      // latency alignment: LAT=3 matches a 3-cycle Q delay
      LAT = 4'd3; qdly = 3; drive_q(); cyc(6);
      pulse_arm();
      wait_state("lat3_run", 2'd2, 30);
      cyc(4);
      for (int i = 0; i < 4; i++) begin
         rd(2'(i));
         chk("lat3_cnt", {28'd0, ERR_CNT}, 32'd0);
      end
      chk("lat3_any", {31'd0, ERR_ANY}, 32'd0);
      pulse_stop();

      // misaligned latency never qualifies
      LAT = 4'd2; cyc(6);
      pulse_arm();
      cyc(30);
      chk("lat2_sync", {30'd0, STATE}, 32'd1);
      chk("lat2_any",  {31'd0, ERR_ANY}, 32'd0);
      pulse_stop();
      chk("lat2_hold", {30'd0, STATE}, 32'd3);

      // saturation on ch1
      LAT = 4'd0; qdly = 0; drive_q(); cyc(6);
      pulse_arm();
      wait_state("sat_run", 2'd2, 30);
      rd(2'd1);
      set_flip(4'b0010); cyc(20); set_flip(4'b0000); cyc(4);
      chk("sat_cnt",  {28'd0, ERR_CNT}, 32'd15);
      chk("sat_flag", {28'd0, ERR_SAT}, 32'd2);
      pulse_clr(); cyc(1);
      chk("sat_clr_cnt",  {28'd0, ERR_CNT}, 32'd0);
      chk("sat_clr_flag", {28'd0, ERR_SAT}, 32'd0);

      // accumulate across runs; frozen in HOLD
      set_flip(4'b0010); cyc(3); set_flip(4'b0000); cyc(4);
      chk("acc_cnt3", {28'd0, ERR_CNT}, 32'd3);
      pulse_stop();
      chk("acc_hold", {30'd0, STATE}, 32'd3);
      set_flip(4'b0010); cyc(5); set_flip(4'b0000); cyc(4);
      chk("acc_frozen", {28'd0, ERR_CNT}, 32'd3);
      pulse_arm();
      wait_state("acc_rerun", 2'd2, 30);
      set_flip(4'b0010); cyc(2); set_flip(4'b0000); cyc(4);
      chk("acc_cnt5", {28'd0, ERR_CNT}, 32'd5);

      // increment on the same edge as CLR: CLR wins
      set_flip(4'b0010); cyc(1); set_flip(4'b0000); cyc(1);
      CLR = 1'b1; cyc(1); CLR = 1'b0;
      cyc(4);
      chk("clr_wins_cnt", {28'd0, ERR_CNT}, 32'd0);
      chk("clr_wins_any", {31'd0, ERR_ANY}, 32'd0);

      // first-error timestamp on ch3 at the 10th RUN cycle
      pulse_stop();
      pulse_arm();
      wait_state("ts_run", 2'd2, 30);
      cyc(7);
      set_flip(4'b1000); cyc(1); set_flip(4'b0000); cyc(4);
      rd(2'd3);
      chk("ts_cnt1", {28'd0, ERR_CNT}, 32'd1);
`ifdef LS_ERR_MON_FIRST_TS_EN
      chk("ts_first", FIRST_TS, 32'd9);
`else
      chk("ts_first", FIRST_TS, 32'd0);
`endif
      set_flip(4'b1000); cyc(2); set_flip(4'b0000); cyc(4);
      chk("ts_cnt3", {28'd0, ERR_CNT}, 32'd3);
`ifdef LS_ERR_MON_FIRST_TS_EN
      chk("ts_keep", FIRST_TS, 32'd9);
`else
      chk("ts_keep", FIRST_TS, 32'd0);
`endif

      // asynchronous reset mid-RUN
      RST = 1'b1;
      #2;
      chk("arst_state", {30'd0, STATE},   32'd0);
      chk("arst_cnt",   {28'd0, ERR_CNT}, 32'd0);
      chk("arst_sat",   {28'd0, ERR_SAT}, 32'd0);
      chk("arst_any",   {31'd0, ERR_ANY}, 32'd0);
      chk("arst_ts",    FIRST_TS,         32'd0);
      cyc(2);
      RST = 1'b0;
      cyc(1);

      // ARM and STOP together from IDLE: STOP wins
      ARM = 1'b1; STOP = 1'b1; cyc(1); ARM = 1'b0; STOP = 1'b0;
      chk("armstop_hold", {30'd0, STATE}, 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
